// File: rtl/down_counter_timer.sv
// Loadable down-counter / interval timer with one-shot and auto-reload modes.
// Emits a registered one-cycle tc pulse at terminal count; done is sticky in one-shot.
module down_counter_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] rld, rld_n;
  logic [WIDTH-1:0] y_n;
  logic             tc_n;
  logic             done_n;

  always_comb begin
    state_n = state;
    y_n     = y;
    rld_n   = rld;
    tc_n    = 1'b0;
    done_n  = done;

    if (load) begin
      rld_n   = load_val;
      y_n     = load_val;
      state_n = IDLE;
      done_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (y != '0)) begin
            state_n = RUN;
            done_n  = 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state_n = PAUSE;
          end else if (y > WIDTH'(1)) begin
            y_n = y - WIDTH'(1);
          end else begin
            // Terminal decision at y==1 so the decrement can never wrap below zero.
            tc_n = 1'b1;
            if (periodic) begin
              y_n = rld;
            end else begin
              y_n     = '0;
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end
        end
        PAUSE: begin
          if (!stop && start) state_n = RUN;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      y     <= '0;
      rld   <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      y     <= y_n;
      rld   <= rld_n;
      tc    <= tc_n;
      done  <= done_n;
    end
  end

  assign busy   = (state == RUN);
  assign paused = (state == PAUSE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them independently.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       periodic = 1'b0;
  logic [7:0] y;
  logic       tc, busy, paused, done;

  down_counter_timer #(.WIDTH(8)) dut (
    .clk(clk), .res(res), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .periodic(periodic), .y(y), .tc(tc), .busy(busy),
    .paused(paused), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [11:0] exp;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  exp_t        cur;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every queued expectation that has come due.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      cur = sbq.pop_front();
      checks++;
      if (cur.due != cyc || {y, tc, busy, paused, done} !== cur.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d: got y=%0d tc=%b busy=%b paused=%b done=%b, want y=%0d tc=%b busy=%b paused=%b done=%b",
                 cur.name, cyc, y, tc, busy, paused, done,
                 cur.exp[11:4], cur.exp[3], cur.exp[2], cur.exp[1], cur.exp[0]);
      end
    end
  end

  task automatic tick(input logic r, input logic ld, input logic [7:0] lv,
                      input logic st, input logic sp, input logic per,
                      input logic [7:0] ey, input logic etc, input logic eb,
                      input logic ep, input logic ed, input string nm);
    exp_t e;
    res = r; load = ld; load_val = lv; start = st; stop = sp; periodic = per;
    e.due  = cyc + 1;
    e.exp  = {ey, etc, eb, ep, ed};
    e.name = nm;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    // Reset from power-up
    tick(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "reset0");
    tick(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "reset1");

    // Reset mid-count at y=5
    tick(0, 1, 8, 0, 0, 0,   8, 0, 0, 0, 0, "rst_load8");
    tick(0, 0, 0, 1, 0, 0,   8, 0, 1, 0, 0, "rst_start");
    tick(0, 0, 0, 0, 0, 0,   7, 0, 1, 0, 0, "rst_run7");
    tick(0, 0, 0, 0, 0, 0,   6, 0, 1, 0, 0, "rst_run6");
    tick(0, 0, 0, 0, 0, 0,   5, 0, 1, 0, 0, "rst_run5");
    tick(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "rst_mid_a");
    tick(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "rst_mid_b");
    tick(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "rst_idle");
    tick(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, "start_y0");

    // One-shot, load 3
    tick(0, 1, 3, 0, 0, 0,   3, 0, 0, 0, 0, "os_load");
    tick(0, 0, 0, 1, 0, 0,   3, 0, 1, 0, 0, "os_start");
    tick(0, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, "os_2");
    tick(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, "os_1");
    tick(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, "os_tc");
    tick(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, "os_after");
    tick(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, "os_hold");
    tick(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, "os_start_y0");

    // Periodic, load 4
    tick(0, 1, 4, 0, 0, 1,   4, 0, 0, 0, 0, "per_load");
    tick(0, 0, 0, 1, 0, 1,   4, 0, 1, 0, 0, "per_start");
    for (int k = 1; k <= 12; k++) begin
      tick(0, 0, 0, 0, 0, 1, (k % 4 == 0) ? 8'd4 : 8'(4 - k % 4),
           (k % 4 == 0), 1, 0, 0, "per_seq");
    end
    tick(0, 0, 0, 0, 1, 1,   4, 0, 0, 1, 0, "per_stop");

    // Pause / resume, load 10
    tick(0, 1, 10, 0, 0, 0,  10, 0, 0, 0, 0, "pr_load");
    tick(0, 0, 0, 1, 0, 0,   10, 0, 1, 0, 0, "pr_start");
    for (int k = 9; k >= 6; k--)
      tick(0, 0, 0, 0, 0, 0, 8'(k), 0, 1, 0, 0, "pr_run");
    tick(0, 0, 0, 0, 1, 0,   6, 0, 0, 1, 0, "pr_stop");
    tick(0, 0, 0, 0, 0, 0,   6, 0, 0, 1, 0, "pr_hold1");
    tick(0, 0, 0, 0, 0, 0,   6, 0, 0, 1, 0, "pr_hold2");
    tick(0, 0, 0, 1, 1, 0,   6, 0, 0, 1, 0, "pr_start_stop");
    tick(0, 0, 0, 0, 0, 0,   6, 0, 0, 1, 0, "pr_hold3");
    tick(0, 0, 0, 0, 0, 0,   6, 0, 0, 1, 0, "pr_hold4");
    tick(0, 0, 0, 1, 0, 0,   6, 0, 1, 0, 0, "pr_resume");
    for (int k = 5; k >= 1; k--)
      tick(0, 0, 0, 0, 0, 0, 8'(k), 0, 1, 0, 0, "pr_down");
    tick(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, "pr_tc");
    tick(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, "pr_after");
    tick(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, "idle_stop");

    // load beats start while running
    tick(0, 1, 5, 0, 0, 0,   5, 0, 0, 0, 0, "pri_load5");
    tick(0, 0, 0, 1, 0, 0,   5, 0, 1, 0, 0, "pri_start");
    tick(0, 0, 0, 0, 0, 0,   4, 0, 1, 0, 0, "pri_4");
    tick(0, 0, 0, 0, 0, 0,   3, 0, 1, 0, 0, "pri_3");
    tick(0, 1, 9, 1, 0, 0,   9, 0, 0, 0, 0, "pri_load_start");
    tick(0, 0, 0, 0, 0, 0,   9, 0, 0, 0, 0, "pri_no_dec");

    // rld=1 periodic, then periodic dropped at decision edge
    tick(0, 1, 1, 0, 0, 1,   1, 0, 0, 0, 0, "r1p_load");
    tick(0, 0, 0, 1, 0, 1,   1, 0, 1, 0, 0, "r1p_start");
    for (int k = 0; k < 4; k++)
      tick(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, "r1p_tc");
    tick(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, "r1p_to_oneshot");

    // rld=1 one-shot
    tick(0, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, "r1o_load");
    tick(0, 0, 0, 1, 0, 0,   1, 0, 1, 0, 0, "r1o_start");
    tick(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, "r1o_tc");
    tick(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, "r1o_after");

    // Full-range one-shot from 255
    tick(0, 1, 255, 0, 0, 0, 255, 0, 0, 0, 0, "max_load");
    tick(0, 0, 0, 1, 0, 0,   255, 0, 1, 0, 0, "max_start");
    for (int k = 1; k <= 254; k++)
      tick(0, 0, 0, 0, 0, 0, 8'(255 - k), 0, 1, 0, 0, "max_down");
    tick(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, "max_tc");
    tick(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, "max_nowrap");

    // Reset out of PAUSE
    tick(0, 1, 7, 0, 0, 0,   7, 0, 0, 0, 0, "rp_load");
    tick(0, 0, 0, 1, 0, 0,   7, 0, 1, 0, 0, "rp_start");
    tick(0, 0, 0, 0, 1, 0,   7, 0, 0, 1, 0, "rp_stop");
    tick(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "rp_reset");
    tick(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, "rp_idle");

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      errors += sbq.size();
      $display("FAIL drain: %0d expectations never compared, want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Loadable down-counter / interval timer: the count-down counterpart to the free-running 8-bit up counter. It counts a loaded value down to terminal count and emits a one-cycle `tc` pulse, in one-shot or periodic (auto-reload) mode. It is used wherever the design needs a programmable delay or a periodic tick derived from `clk`.

## Interface
- `WIDTH`, default 8: counter and load-value width in bits.

- `clk`: input, 1 bit. System clock; all state changes on its rising edge.
- `res`: input, 1 bit. Reset. **Synchronous, active-high.**
- `load`: input, 1 bit. Single-cycle strobe; captures `load_val` into the reload register and into `y`.
- `load_val`: input, WIDTH bits. Value captured on `load`.
- `start`: input, 1 bit. Starts the count from IDLE, or resumes it from PAUSE.
- `stop`: input, 1 bit. Pauses a running count.
- `periodic`: input, 1 bit. 1 selects auto-reload at terminal count; 0 selects one-shot.
- `y`: output, WIDTH bits. Current count (registered).
- `tc`: output, 1 bit. Terminal-count pulse, one cycle wide (registered).
- `busy`: output, 1 bit. High when state = RUN.
- `paused`: output, 1 bit. High when state = PAUSE.
- `done`: output, 1 bit. Sticky one-shot completion flag.

## Operation
- **Registers:** `y`, `rld` (reload value), state {IDLE, RUN, PAUSE}, `tc`, `done`.
- **Priority per edge:** `res` > `load` > `stop` > `start` > counting.
- **`res`=1:**
  - `y`=0, `rld`=0, state=IDLE.
  - `tc`=0, `busy`=0, `paused`=0, `done`=0.
  - Applies from any state, including mid-count.
- **`load`=1 (any state):**
  - `rld`←`load_val`, `y`←`load_val`, state←IDLE, `done`←0.
  - `tc`=0 that cycle; a simultaneous `start`/`stop` is ignored.
- **IDLE:**
  - `start` with `y`≠0 → RUN, `done`←0.
  - `start` with `y`=0 is ignored (stays IDLE, no `tc`).
  - `stop` has no effect.
- **RUN:**
  - `stop` → PAUSE; `y` holds.
  - Otherwise, if `y`>1: `y`←`y`−1.
  - If `y`=1 and `periodic`=0: `y`←0, `tc`←1, `done`←1, state←IDLE.
  - If `y`=1 and `periodic`=1: `y`←`rld`, `tc`←1, stay in RUN; `y` never shows 0.
  - `periodic` is sampled only at the `y`=1 decision edge; changing it mid-count is legal.
  - RUN with `y`=0 is unreachable.
- **PAUSE:**
  - `start` → RUN; counting resumes from the held `y`.
  - `start` and `stop` together: stop wins, stays in PAUSE.
  - Otherwise holds.
- **`tc`:** high for exactly one cycle after each terminal edge, 0 otherwise.
- **Arithmetic:** unsigned WIDTH-bit. The decrement never wraps below 0, because the terminal decision is taken at `y`=1.
- **Periodic period:** `rld` cycles between `tc` pulses. `rld`=1 gives `tc` every cycle with `y` constantly 1.
- **`done`:** cleared by `res`, `load`, or an accepted `start` from IDLE.

## Timing
- **`start` accepted at edge N:** state=RUN after N; `y` unchanged at N; first decrement at edge N+1.
- **One-shot:** `y`=0 and `tc`=1 after edge N+`rld`. `busy` drops in the same cycle, and `tc` drops after N+`rld`+1.
- **Periodic:** `tc` after edges N+`rld`, N+2·`rld`, …
- **`stop` at edge M:** `y` frozen at its value before M. Resume `start` at edge P; decrement resumes at P+1.
- **Outputs:** all registered; no combinational path from input to output.
- **`busy`/`paused`:** decoded directly from state.

## Test plan
- **Reset:** assert `res` 2 cycles mid-count (`y`=5, RUN) → next cycle `y`=0, `rld`=0, `tc`=`busy`=`paused`=`done`=0, state IDLE.
- **One-shot:** `load_val`=3, `load`, then `start`, `periodic`=0 → `y` sequence 3,3,2,1,0; `tc`=1 for one cycle at `y`=0; `busy` 1→0; `done`=1; `y` stays 0.
- **Periodic:** `load_val`=4, `periodic`=1, `start` → `y` 4,3,2,1,4,3,2,1,…; `tc` once every 4 cycles, coincident with `y`=4 reload; `busy` stays 1.
- **Pause/resume:** `rld`=10; `stop` when `y`=6 → `paused`=1, `y` holds 6 for 5 cycles. Then `start` → `y` 6,5,…,0 with `tc`; a `start`+`stop` pulse mid-pause leaves `y`=6.
- **Priority:**
  - `load`(`load_val`=9) together with `start` while RUN at `y`=3 → `y`=9, state IDLE, no decrement.
  - `start` with `y`=0 → nothing happens.
  - `WIDTH`=8, `load_val`=255 one-shot → 255 decrements to 0, no wrap.
- **Edge values:** `rld`=1 periodic → `tc` every cycle, `y`=1. `rld`=1 one-shot → `tc` at N+1, `y`=0.
